// File: rtl/keypad_encoder_debounced_pkg.sv
// Shared types and helpers for the debounced keypad encoder.
// Covers the FSM state type, the all-ones error code and the lowest-set-bit search.
package keypad_pkg;

    localparam int MAX_KEYS = 64;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } kp_state_t;

    // All-ones value of the given code width, returned right-aligned in 32 bits.
    function automatic logic [31:0] INVALID_CODE(input int codeW);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < codeW) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic int lowest_set_index(input logic [MAX_KEYS-1:0] v);
        int idx;
        idx = 0;
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_encoder_debounced_key_sync.sv
// Two-flop synchroniser for the raw key inputs.
// A synchronous clear empties both stages.
module key_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_encoder_debounced.sv
// Debounced N-key encoder with press/release events, optional auto-repeat and
// a choice of strict or lowest-index-wins handling of multi-key patterns.
module keypad_encoder_debounced
    import keypad_pkg::*;
#(
    parameter int NUM_KEYS        = 10,
    parameter int CODE_W          = $clog2(NUM_KEYS),
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PRIORITY_MODE   = 0,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [CODE_W-1:0]   code,
    output logic                valid,
    output logic                press_pulse,
    output logic                release_pulse,
    output logic                error
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RPT_W = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0]  RPT_MAX  = RPT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [CODE_W-1:0] INV_CODE = CODE_W'(INVALID_CODE(CODE_W));

    logic                clear;
    logic [NUM_KEYS-1:0] keysS;
    logic                anyKey;
    logic                multiKey;
    logic                strictMulti;
    logic [CODE_W-1:0]   candCode;

    kp_state_t           state_q;
    logic [NUM_KEYS-1:0] pat_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [RPT_W-1:0]    rpt_q;
    logic                fromPressed_q;

    assign clear = rst || !enable;

    key_sync #(.WIDTH(NUM_KEYS)) u_sync (
        .clk_i (clk),
        .clr_i (clear),
        .d_i   (keys),
        .q_o   (keysS)
    );

    // Clearing the lowest set bit leaves something only when two or more keys are down.
    assign anyKey      = |keysS;
    assign multiKey    = |(keysS & (keysS - NUM_KEYS'(1)));
    assign strictMulti = (PRIORITY_MODE == 0) && multiKey;
    assign candCode    = strictMulti ? INV_CODE
                                     : CODE_W'(lowest_set_index(MAX_KEYS'(keysS)));

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q       <= IDLE;
            pat_q         <= '0;
            cnt_q         <= '0;
            rpt_q         <= '0;
            fromPressed_q <= 1'b0;
            code          <= '0;
            valid         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            error         <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            error         <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (anyKey) begin
                        state_q <= DEBOUNCE;
                        pat_q   <= keysS;
                        cnt_q   <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (!anyKey) begin
                        state_q <= IDLE;
                    end else if (keysS != pat_q) begin
                        pat_q <= keysS;
                        cnt_q <= '0;
                    end else if (cnt_q < CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else if (strictMulti) begin
                        // Rejected chord waits out a full release without ever asserting valid.
                        state_q       <= RELEASE;
                        code          <= INV_CODE;
                        error         <= 1'b1;
                        cnt_q         <= '0;
                        fromPressed_q <= 1'b0;
                    end else begin
                        state_q     <= PRESSED;
                        code        <= candCode;
                        valid       <= 1'b1;
                        press_pulse <= 1'b1;
                        rpt_q       <= '0;
                    end
                end
                PRESSED: begin
                    if (keysS == pat_q) begin
                        if (REPEAT_CYCLES > 0) begin
                            if (rpt_q == RPT_MAX) begin
                                press_pulse <= 1'b1;
                                rpt_q       <= '0;
                            end else begin
                                rpt_q <= rpt_q + 1'b1;
                            end
                        end
                    end else begin
                        state_q       <= RELEASE;
                        cnt_q         <= '0;
                        fromPressed_q <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!anyKey) begin
                        if (cnt_q == CNT_MAX) begin
                            state_q       <= IDLE;
                            valid         <= 1'b0;
                            release_pulse <= fromPressed_q;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if ((keysS == pat_q) && fromPressed_q) begin
                        state_q <= PRESSED;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_encoder_debounced.sv
// Bench for keypad_encoder_debounced: a strict/default instance and a priority/repeat
// instance share one key bus and are compared each cycle against a run-length model.
module tb_keypad_encoder_debounced;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [9:0] keys;

    logic [3:0] codeA, codeB;
    logic       validA, validB, pressA, pressB, relA, relB, errA, errB;

    int errors = 0;
    int checks = 0;
    int edgeNo = 0;

    logic [9:0] mS1[2], mS2[2], mPrev[2], mAcc[2], mLastNz[2];
    int         mRun[2], mZero[2], mHeld[2], mCode[2];
    bit         mEng[2], mErr[2], mValid[2], mPress[2], mRel[2], mErrP[2];

    int pressCnt[2], relCnt[2], errCnt[2], firstPress[2];

    keypad_encoder_debounced dutA (
        .clk(clk), .rst(rst), .enable(enable), .keys(keys),
        .code(codeA), .valid(validA), .press_pulse(pressA),
        .release_pulse(relA), .error(errA)
    );

    keypad_encoder_debounced #(
        .NUM_KEYS(10), .DEBOUNCE_CYCLES(3), .PRIORITY_MODE(1), .REPEAT_CYCLES(8)
    ) dutB (
        .clk(clk), .rst(rst), .enable(enable), .keys(keys),
        .code(codeB), .valid(validB), .press_pulse(pressB),
        .release_pulse(relB), .error(errB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lowIdx(input logic [9:0] v);
        for (int i = 0; i < 10; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Model: a press is accepted when the synchronised pattern has been identical for
    // D+1 sampling edges while no key is engaged; a release needs a run of zero samples.
    task automatic modelStep();
        for (int m = 0; m < 2; m++) begin
            logic [9:0] ks;
            int d, r, need;
            bit prio;
            d    = (m == 0) ? 4 : 3;
            r    = (m == 0) ? 0 : 8;
            prio = (m == 1);
            ks   = mS2[m];
            mPress[m] = 0; mRel[m] = 0; mErrP[m] = 0;
            if (rst || !enable) begin
                mS1[m] = '0; mS2[m] = '0; mPrev[m] = '0; mAcc[m] = '0; mLastNz[m] = '0;
                mRun[m] = 0; mZero[m] = 0; mHeld[m] = 0; mCode[m] = 0;
                mEng[m] = 0; mErr[m] = 0; mValid[m] = 0;
            end else begin
                mS2[m] = mS1[m];
                mS1[m] = keys;
                if (ks == mPrev[m]) begin
                    if (mRun[m] < 100000) mRun[m]++;
                end else begin
                    mRun[m] = 1;
                end
                if (!mEng[m]) begin
                    if (ks != 0 && mRun[m] == d + 1) begin
                        mEng[m] = 1; mAcc[m] = ks; mLastNz[m] = ks; mZero[m] = 0;
                        if (!prio && $countones(ks) > 1) begin
                            mErr[m] = 1; mCode[m] = 15; mErrP[m] = 1;
                        end else begin
                            mErr[m] = 0; mCode[m] = lowIdx(ks); mValid[m] = 1;
                            mPress[m] = 1; mHeld[m] = 0;
                        end
                    end
                end else if (ks == 0) begin
                    mZero[m]++;
                    need = (mLastNz[m] == mAcc[m] && !mErr[m]) ? d + 1 : d;
                    if (mZero[m] == need) begin
                        mEng[m] = 0;
                        if (!mErr[m]) begin mValid[m] = 0; mRel[m] = 1; end
                    end
                end else begin
                    mZero[m] = 0;
                    mLastNz[m] = ks;
                    if (!mErr[m] && r > 0 && ks == mAcc[m] && mPrev[m] == mAcc[m]) begin
                        mHeld[m]++;
                        if (mHeld[m] == r) begin mPress[m] = 1; mHeld[m] = 0; end
                    end
                end
                mPrev[m] = ks;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edgeNo);
        end
    endtask

    task automatic checkAllOutputs();
        checkOutput("A.code",    32'(codeA),  32'(mCode[0]));
        checkOutput("A.valid",   32'(validA), 32'(mValid[0]));
        checkOutput("A.press",   32'(pressA), 32'(mPress[0]));
        checkOutput("A.release", 32'(relA),   32'(mRel[0]));
        checkOutput("A.error",   32'(errA),   32'(mErrP[0]));
        checkOutput("B.code",    32'(codeB),  32'(mCode[1]));
        checkOutput("B.valid",   32'(validB), 32'(mValid[1]));
        checkOutput("B.press",   32'(pressB), 32'(mPress[1]));
        checkOutput("B.release", 32'(relB),   32'(mRel[1]));
        checkOutput("B.error",   32'(errB),   32'(mErrP[1]));
        if (pressA === 1'b1) begin pressCnt[0]++; if (firstPress[0] < 0) firstPress[0] = edgeNo; end
        if (pressB === 1'b1) begin pressCnt[1]++; if (firstPress[1] < 0) firstPress[1] = edgeNo; end
        if (relA === 1'b1) relCnt[0]++;
        if (relB === 1'b1) relCnt[1]++;
        if (errA === 1'b1) errCnt[0]++;
        if (errB === 1'b1) errCnt[1]++;
    endtask

    task automatic clearCounters();
        for (int m = 0; m < 2; m++) begin
            pressCnt[m] = 0; relCnt[m] = 0; errCnt[m] = 0; firstPress[m] = -1;
        end
    endtask

    task automatic applyStimulus(input logic [9:0] k, input int n);
        keys = k;
        repeat (n) begin
            @(posedge clk);
            edgeNo++;
            modelStep();
            @(negedge clk);
            checkAllOutputs();
        end
    endtask

    initial begin
        int start;
        rst = 1'b1; enable = 1'b1; keys = '0;
        clearCounters();
        for (int m = 0; m < 2; m++) begin
            mS1[m] = '0; mS2[m] = '0; mPrev[m] = '0; mAcc[m] = '0; mLastNz[m] = '0;
            mRun[m] = 0; mZero[m] = 0; mHeld[m] = 0; mCode[m] = 0;
            mEng[m] = 0; mErr[m] = 0; mValid[m] = 0; mPress[m] = 0; mRel[m] = 0; mErrP[m] = 0;
        end
        applyStimulus(10'd0, 3);
        checkOutput("reset.A.code", 32'(codeA), 32'd0);
        checkOutput("reset.B.valid", 32'(validB), 32'd0);
        rst = 1'b0;
        applyStimulus(10'd0, 2);

        $display("[TB] single key 3");
        clearCounters(); start = edgeNo;
        applyStimulus(10'b0000001000, 20);
        checkOutput("key3.A.latency", 32'(firstPress[0] - start), 32'd7);
        checkOutput("key3.B.latency", 32'(firstPress[1] - start), 32'd6);
        checkOutput("key3.A.presses", 32'(pressCnt[0]), 32'd1);
        checkOutput("key3.B.presses", 32'(pressCnt[1]), 32'd2);
        checkOutput("key3.A.code", 32'(codeA), 32'd3);
        clearCounters();
        applyStimulus(10'd0, 10);
        checkOutput("key3.A.releases", 32'(relCnt[0]), 32'd1);
        checkOutput("key3.B.releases", 32'(relCnt[1]), 32'd1);
        checkOutput("key3.A.codeHeld", 32'(codeA), 32'd3);
        checkOutput("key3.A.validLow", 32'(validA), 32'd0);

        $display("[TB] bounce on key 5");
        clearCounters();
        for (int i = 0; i < 5; i++) applyStimulus((i % 2 == 0) ? 10'b0000100000 : 10'd0, 2);
        checkOutput("bounce.A.noPress", 32'(pressCnt[0]), 32'd0);
        applyStimulus(10'b0000100000, 10);
        checkOutput("bounce.A.presses", 32'(pressCnt[0]), 32'd1);
        checkOutput("bounce.B.presses", 32'(pressCnt[1]), 32'd1);
        checkOutput("bounce.A.code", 32'(codeA), 32'd5);
        applyStimulus(10'd0, 10);

        $display("[TB] two keys 2 and 7");
        clearCounters();
        applyStimulus(10'b0010000100, 15);
        checkOutput("multi.A.errors", 32'(errCnt[0]), 32'd1);
        checkOutput("multi.A.presses", 32'(pressCnt[0]), 32'd0);
        checkOutput("multi.A.code", 32'(codeA), 32'd15);
        checkOutput("multi.B.errors", 32'(errCnt[1]), 32'd0);
        checkOutput("multi.B.presses", 32'(pressCnt[1]), 32'd2);
        checkOutput("multi.B.code", 32'(codeB), 32'd2);
        applyStimulus(10'b0000000100, 6);
        checkOutput("multi.B.validHeld", 32'(validB), 32'd1);
        clearCounters();
        applyStimulus(10'd0, 10);
        checkOutput("multi.A.noRelease", 32'(relCnt[0]), 32'd0);
        checkOutput("multi.B.release", 32'(relCnt[1]), 32'd1);
        applyStimulus(10'b0000000010, 15);
        checkOutput("multi.A.codeAfter", 32'(codeA), 32'd1);
        applyStimulus(10'd0, 10);

        $display("[TB] auto-repeat on key 9");
        clearCounters();
        applyStimulus(10'b1000000000, 50);
        checkOutput("repeat.B.presses", 32'(pressCnt[1]), 32'd6);
        checkOutput("repeat.A.presses", 32'(pressCnt[0]), 32'd1);
        checkOutput("repeat.B.code", 32'(codeB), 32'd9);

        $display("[TB] enable drop while held");
        clearCounters();
        enable = 1'b0;
        applyStimulus(10'b1000000000, 1);
        checkOutput("drop.A.valid", 32'(validA), 32'd0);
        checkOutput("drop.noRelease", 32'(relCnt[0] + relCnt[1]), 32'd0);
        enable = 1'b1;
        clearCounters(); start = edgeNo;
        applyStimulus(10'b1000000000, 12);
        checkOutput("drop.A.latency", 32'(firstPress[0] - start), 32'd7);
        checkOutput("drop.B.latency", 32'(firstPress[1] - start), 32'd6);
        applyStimulus(10'd0, 10);

        $display("[TB] random patterns");
        for (int s = 0; s < 300; s++) begin
            int r;
            int hold;
            logic [9:0] k;
            r = int'($urandom_range(0, 19));
            hold = int'($urandom_range(1, 20));
            k = '0;
            if (r >= 5 && r < 13) begin
                k = 10'(1) << $urandom_range(0, 9);
            end else if (r >= 13 && r < 18) begin
                k = (10'(1) << $urandom_range(0, 9)) | (10'(1) << $urandom_range(0, 9));
            end else if (r == 18) begin
                rst = 1'b1; hold = 1;
            end else if (r == 19) begin
                enable = 1'b0; hold = 1;
            end
            applyStimulus(k, hold);
            rst = 1'b0;
            enable = 1'b1;
        end
        applyStimulus(10'd0, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_encoder_debounced.md
Name: keypad_encoder_debounced

Overview:
Parametrised successor to the front-panel keypad encoder.
- Converts an N-key button vector into a binary key code.
- Adds input synchronisation, a proper press/release debounce FSM, selectable multi-key handling, one-cycle press/release events and optional auto-repeat.
- Sits between the raw panel buttons and the microwave time-entry/control logic.

Parameters:
NUM_KEYS, 10, number of key inputs (>=2)
CODE_W, $clog2(NUM_KEYS), width of code output
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a press or a release (>=1)
PRIORITY_MODE, 0, 0 = strict (multi-key is an error); 1 = lowest-index key wins
REPEAT_CYCLES, 0, auto-repeat period in cycles while held; 0 disables repeat

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  block enable; low = synchronous clear, same as rst
keys  in  NUM_KEYS  raw asynchronous buttons, keys[i] = key i, active high
code  out  CODE_W  encoded key index; all-ones (INVALID_CODE) on a strict-mode error
valid  out  1  high while an accepted key is held
press_pulse  out  1  one-cycle pulse on accepted press and on each repeat
release_pulse  out  1  one-cycle pulse on accepted release
error  out  1  one-cycle pulse when a debounced multi-key pattern is detected in strict mode

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high. rst has priority over enable. enable=0 has the identical effect.
- On reset or clear:
  - state=IDLE, counters=0, synchroniser=0.
  - code=0, valid=0, press_pulse=0, release_pulse=0, error=0.
- All outputs are registered.
- Synchroniser: 2-flop chain on keys produces keys_s.
- Decode of keys_s:
  - any = |keys_s; multi = more than one bit set.
  - cand = index of the lowest set bit.
  - In strict mode with multi set, cand = INVALID_CODE.
- FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE.
- IDLE:
  - If any: go to DEBOUNCE, pat <= keys_s, cnt <= 0.
- DEBOUNCE:
  - keys_s==0: go to IDLE, no output.
  - keys_s!=pat and keys_s!=0: pat <= keys_s, cnt <= 0 (restart).
  - keys_s==pat and cnt<DEBOUNCE_CYCLES-1: cnt++.
  - keys_s==pat and cnt==DEBOUNCE_CYCLES-1, with !(strict and multi): go to PRESSED, code <= cand, valid <= 1, press_pulse for 1 cycle, rpt <= 0.
  - Same condition but strict and multi: go to RELEASE, code <= INVALID_CODE, error for 1 cycle, valid stays 0.
- Press latency: press_pulse is high in the cycle after clock edge DEBOUNCE_CYCLES+3, counting from the first edge that samples the stable keys pattern. This is 7 cycles for the default.
- PRESSED:
  - keys_s==pat: hold. If REPEAT_CYCLES>0, rpt++; when rpt reaches REPEAT_CYCLES-1, press_pulse for 1 cycle and rpt <= 0.
  - keys_s!=pat: go to RELEASE, cnt <= 0. valid stays 1 until the release is accepted.
- RELEASE:
  - keys_s==0: cnt++. When cnt==DEBOUNCE_CYCLES-1, go to IDLE, valid <= 0, release_pulse for 1 cycle. code holds its last value.
  - keys_s==pat and the entry came from PRESSED: treat as a bounce. Return to PRESSED with no pulse; rpt is kept.
  - Any other non-zero pattern: cnt <= 0 and stay in RELEASE. No key rollover: a new key is accepted only after a full debounced release.
  - After an error entry, valid stays 0 and no release_pulse is generated.
- Counter widths:
  - cnt is $clog2(DEBOUNCE_CYCLES)+1 bits.
  - rpt is $clog2(REPEAT_CYCLES)+1 bits.
  - Neither counter wraps; each saturates at compare.
- Reset or enable low mid-press: immediate clear next edge; no release_pulse is emitted.

Decomposition:
- Package keypad_pkg contains:
  - the kp_state_t enum (IDLE, DEBOUNCE, PRESSED, RELEASE);
  - the INVALID_CODE function (all ones of CODE_W);
  - a lowest-set-bit index function.
- Sub-module key_sync: parameter WIDTH; 2-flop synchroniser with synchronous reset/clear. It is instantiated once.

Test Plan:
- Defaults; keys=10'b0000001000 held 20 cycles, then 0 -> press_pulse once at edge 7, code=3, valid=1; release_pulse 4+ edges after keys_s==0, valid=0, code stays 3.
- Bounce: keys toggles 0/bit5 every 2 cycles for 10 cycles, then holds bit5 -> no pulse during bouncing; single press_pulse with code=5 after 4 stable cycles.
- Strict multi: keys=bits 2 and 7 held -> error pulse once, code=15, valid=0, no press_pulse; after full release, a single key=1 is accepted with code=1.
- PRIORITY_MODE=1: keys=bits 2 and 7 -> code=2, press_pulse; releasing only bit 7 goes to RELEASE (pattern changed); valid stays 1 until all keys are released and debounced.
- REPEAT_CYCLES=8: hold key 9 for 40 cycles after acceptance -> press_pulse at acceptance, then every 8 cycles (5 extra pulses), code=9 throughout.
- Reset/enable: drop enable for 1 cycle while PRESSED -> next cycle all outputs 0, no release_pulse; with the key still held after enable returns, a fresh press is accepted at edge 7 relative to re-enable.
